// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM driving a shared-ALU, shared-memory datapath.
// Optional MC_MEM_WAIT_EN adds a MemReady input that stretches FETCH/MEMREAD/MEMWRITE.
module mc_controller #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7_5,
   input  logic                 Zero,
`ifdef MC_MEM_WAIT_EN
   input  logic                 MemReady,
`endif
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [2:0]           ALUControl,
   output logic [1:0]           ImmSrc,
   output logic                 RegWrite,
   output logic                 InstrDone,
   output logic                 Illegal,
   output logic [INSTRET_W-1:0] Instret,
   output logic [3:0]           State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALRADR  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t state_q, state_d;
   logic   mem_ready;
   logic   pc_write, mem_write, ir_write, reg_write, instr_done, illegal;

`ifdef MC_MEM_WAIT_EN
   assign mem_ready = MemReady;
`else
   assign mem_ready = 1'b1;
`endif

   // Shared R/I decode; only R-type with funct7_5 turns funct3=000 into sub.
   function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
      case (f3)
         3'b000:  alu_decode = sub_ok ? ALU_SUB : ALU_ADD;
         3'b010:  alu_decode = ALU_SLT;
         3'b110:  alu_decode = ALU_OR;
         3'b111:  alu_decode = ALU_AND;
         default: alu_decode = ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         Instret <= '0;
      end else begin
         state_q <= state_d;
         if (InstrDone) Instret <= Instret + INSTRET_W'(1);
      end
   end

   always_comb begin
      state_d    = S_FETCH;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      ImmSrc     = 2'b00;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            state_d   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Precompute the branch/jal target into ALUOut while decoding.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b10;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALRADR;
               OP_BRANCH: begin
                  if (funct3 == 3'b000 || funct3 == 3'b001) state_d = S_BRANCH;
                  else illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (op == OP_STORE) ? 2'b01 : 2'b00;
            state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_decode(funct3, funct7_5);
            state_d    = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_decode(funct3, 1'b0);
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            pc_write   = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);
            instr_done = 1'b1;
         end
         S_JAL: begin
            // PC takes the target while ALUOut captures the link address.
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pc_write = 1'b1;
            state_d  = S_ALUWB;
         end
         S_JALRADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = S_JAL;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign PCWrite   = pc_write & ~rst;
   assign MemWrite  = mem_write & ~rst;
   assign IRWrite   = ir_write & ~rst;
   assign RegWrite  = reg_write & ~rst;
   assign InstrDone = instr_done & ~rst;
   assign Illegal   = illegal & ~rst;
   assign State     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle expected output words queued from a state table and popped at negedge.
`timescale 1ns/1ps
module tb_mc_controller;
   localparam int IW = 4;
   localparam int W  = 22;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic funct7_5 = 1'b0;
   logic Zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
   logic MemReady = 1'b1;
`endif
   logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [IW-1:0] Instret;
   logic [3:0] State;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs, e;
   logic [IW-1:0] exp_instret = '0;
   int total = 0;
   int bad = 0;

   mc_controller #(.INSTRET_W(IW)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
`ifdef MC_MEM_WAIT_EN
      .MemReady(MemReady),
`endif
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .InstrDone(InstrDone), .Illegal(Illegal),
      .Instret(Instret), .State(State)
   );

   always #5 clk = ~clk;

   assign obs = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, ImmSrc, RegWrite, InstrDone, Illegal};

   function automatic logic [W-1:0] pk(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [1:0] imm, input logic rw, input logic dn, input logic il);
      return {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, il};
   endfunction

   function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic f7, input logic is_r);
      case (f3)
         3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic exp_illegal(input logic [6:0] o, input logic [2:0] f3);
      if (o == OP_BR) return !(f3 == 3'b000 || f3 == 3'b001);
      return !(o == OP_LOAD || o == OP_STORE || o == OP_R || o == OP_I || o == OP_JAL || o == OP_JALR);
   endfunction

   function automatic logic [W-1:0] exp_word(input logic [3:0] st, input logic [6:0] o,
                                             input logic [2:0] f3, input logic f7, input logic z);
      case (st)
         4'd0:  return pk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
         4'd1:  return pk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd0, 2'd2, 1'b0, 1'b0,
                          exp_illegal(o, f3));
         4'd2:  return pk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0,
                          (o == OP_STORE) ? 2'd1 : 2'd0, 1'b0, 1'b0, 1'b0);
         4'd3:  return pk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
         4'd4:  return pk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0);
         4'd5:  return pk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
         4'd6:  return pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, exp_alu(f3, f7, 1'b1), 2'd0,
                          1'b0, 1'b0, 1'b0);
         4'd7:  return pk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, exp_alu(f3, f7, 1'b0), 2'd0,
                          1'b0, 1'b0, 1'b0);
         4'd8:  return pk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0);
         4'd9:  return pk(4'd9, (f3 == 3'b000 && z) || (f3 == 3'b001 && !z), 1'b0, 1'b0, 1'b0, 2'd0,
                          2'd2, 2'd0, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0);
         4'd10: return pk(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
         default: return pk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      endcase
   endfunction

   // Drive instruction fields and queue the state-by-state expected trace.
   task automatic start_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      logic [19:0] code;
      int n;
      op = o; funct3 = f3; funct7_5 = f7; Zero = z;
      case (o)
         OP_LOAD:  begin code = 20'h01234; n = 5; end
         OP_STORE: begin code = 20'h01250; n = 4; end
         OP_R:     begin code = 20'h01680; n = 4; end
         OP_I:     begin code = 20'h01780; n = 4; end
         OP_JAL:   begin code = 20'h01A80; n = 4; end
         OP_JALR:  begin code = 20'h01BA8; n = 5; end
         OP_BR:    begin code = 20'h01900; n = exp_illegal(o, f3) ? 2 : 3; end
         default:  begin code = 20'h01000; n = 2; end
      endcase
      for (int i = 0; i < n; i++) exp_q.push_back(exp_word(code[19-4*i -: 4], o, f3, f7, z));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total++;
         if ({State, PCWrite, IRWrite, MemWrite, RegWrite, InstrDone, Illegal} !== 10'd0) begin
            bad++;
            $display("FAIL reset_hold: got state=%0d strobes=%b want state=0 strobes=000000", State,
                     {PCWrite, IRWrite, MemWrite, RegWrite, InstrDone, Illegal});
         end
      end
      @(posedge clk); #1 rst = 1'b0;
      #1;
      total++;
      if (obs !== exp_word(4'd0, OP_LOAD, 3'd0, 1'b0, 1'b0)) begin
         bad++; $display("FAIL reset_fetch: got=%h want=%h", obs, exp_word(4'd0, OP_LOAD, 3'd0, 1'b0, 1'b0));
      end
      total++;
      if (Instret !== '0) begin bad++; $display("FAIL reset_instret: got=%0d want=0", Instret); end
      exp_instret = '0;
   endtask

   task automatic test_load_store();
      logic [6:0] ops[2] = '{OP_LOAD, OP_STORE};
      for (int k = 0; k < 2; k++) begin
         start_instr(ops[k], 3'b010, 1'b0, 1'b0);
         while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL mem op=%b: got=%h want=%h", ops[k], obs, e); end
            if (e[1]) exp_instret++;
            @(posedge clk); #1;
         end
         total++;
         if (Instret !== exp_instret) begin
            bad++; $display("FAIL mem_instret: got=%0d want=%0d", Instret, exp_instret);
         end
      end
   endtask

   task automatic test_alu();
      logic [2:0] f3s[5] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
      logic       f7s[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 10; k++) begin
         start_instr((k < 5) ? OP_R : OP_I, f3s[k % 5], f7s[k % 5], 1'b0);
         while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL alu k=%0d: got=%h want=%h", k, obs, e); end
            if (e[1]) exp_instret++;
            @(posedge clk); #1;
         end
         total++;
         if (Instret !== exp_instret) begin
            bad++; $display("FAIL alu_instret: got=%0d want=%0d", Instret, exp_instret);
         end
      end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 4; k++) begin
         start_instr(OP_BR, (k < 2) ? 3'b000 : 3'b001, 1'b0, k[0]);
         while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL branch k=%0d: got=%h want=%h", k, obs, e); end
            if (e[1]) exp_instret++;
            @(posedge clk); #1;
         end
         total++;
         if (Instret !== exp_instret) begin
            bad++; $display("FAIL branch_instret: got=%0d want=%0d", Instret, exp_instret);
         end
      end
   endtask

   task automatic test_jumps();
      logic [6:0] ops[2] = '{OP_JAL, OP_JALR};
      for (int k = 0; k < 2; k++) begin
         start_instr(ops[k], 3'b000, 1'b0, 1'b0);
         while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL jump op=%b: got=%h want=%h", ops[k], obs, e); end
            if (e[1]) exp_instret++;
            @(posedge clk); #1;
         end
         total++;
         if (Instret !== exp_instret) begin
            bad++; $display("FAIL jump_instret: got=%0d want=%0d", Instret, exp_instret);
         end
      end
   endtask

   task automatic test_illegal();
      logic [6:0] ops[3] = '{7'b0000000, OP_BR, OP_BR};
      logic [2:0] f3s[3] = '{3'b000, 3'b010, 3'b111};
      for (int k = 0; k < 3; k++) begin
         start_instr(ops[k], f3s[k], 1'b0, 1'b1);
         while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL illegal k=%0d: got=%h want=%h", k, obs, e); end
            if (e[1]) exp_instret++;
            @(posedge clk); #1;
         end
         total++;
         if (Instret !== exp_instret) begin
            bad++; $display("FAIL illegal_instret: got=%0d want=%0d", Instret, exp_instret);
         end
      end
   endtask

   task automatic test_reset_midway();
      op = OP_LOAD; funct3 = 3'b010; funct7_5 = 1'b0; Zero = 1'b0;
      for (int s = 0; s < 3; s++) exp_q.push_back(exp_word(4'(s), OP_LOAD, 3'b010, 1'b0, 1'b0));
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; $display("FAIL midrst_pre: got=%h want=%h", obs, e); end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if ({State, PCWrite, IRWrite, MemWrite, RegWrite, InstrDone, Illegal} !==
             {(c == 0) ? 4'd3 : 4'd0, 6'b000000}) begin
            bad++;
            $display("FAIL midrst_hold c=%0d: got state=%0d strobes=%b want state=%0d strobes=000000", c,
                     State, {PCWrite, IRWrite, MemWrite, RegWrite, InstrDone, Illegal}, (c == 0) ? 3 : 0);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      total++;
      if (obs !== exp_word(4'd0, OP_LOAD, 3'd0, 1'b0, 1'b0)) begin
         bad++; $display("FAIL midrst_fetch: got=%h want=%h", obs, exp_word(4'd0, OP_LOAD, 3'd0, 1'b0, 1'b0));
      end
      exp_instret = '0;
      total++;
      if (Instret !== exp_instret) begin bad++; $display("FAIL midrst_instret: got=%0d want=0", Instret); end
   endtask

   // Random legal mix long enough to wrap the narrow retired counter.
   task automatic test_back_to_back();
      logic [6:0] ops[7] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR};
      logic [2:0] alu_f3[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
      logic [6:0] o;
      logic [2:0] f3;
      for (int k = 0; k < 22; k++) begin
         o = ops[$urandom_range(0, 6)];
         if (o == OP_BR) f3 = 3'($urandom_range(0, 1));
         else if (o == OP_R || o == OP_I) f3 = alu_f3[$urandom_range(0, 3)];
         else f3 = 3'($urandom_range(0, 7));
         start_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL b2b k=%0d op=%b: got=%h want=%h", k, o, obs, e); end
            if (e[1]) exp_instret++;
            @(posedge clk); #1;
         end
         total++;
         if (Instret !== exp_instret) begin
            bad++; $display("FAIL b2b_instret k=%0d: got=%0d want=%0d", k, Instret, exp_instret);
         end
      end
   endtask

`ifdef MC_MEM_WAIT_EN
   task automatic test_mem_wait();
      op = OP_STORE; funct3 = 3'b010; funct7_5 = 1'b0; Zero = 1'b0;
      for (int s = 0; s < 3; s++) exp_q.push_back(exp_word(4'(s), OP_STORE, 3'b010, 1'b0, 1'b0));
      repeat (3) exp_q.push_back(pk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0,
                                    1'b0, 1'b0, 1'b0));
      exp_q.push_back(exp_word(4'd5, OP_STORE, 3'b010, 1'b0, 1'b0));
      for (int i = 0; i < 7; i++) begin
         MemReady = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; $display("FAIL memwait i=%0d: got=%h want=%h", i, obs, e); end
         if (e[1]) exp_instret++;
         @(posedge clk); #1;
      end
      MemReady = 1'b1;
      total++;
      if (Instret !== exp_instret) begin
         bad++; $display("FAIL memwait_instret: got=%0d want=%0d", Instret, exp_instret);
      end
      total++;
      if (State !== 4'd0) begin bad++; $display("FAIL memwait_return: got state=%0d want=0", State); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_store();
      test_alu();
      test_branch();
      test_jumps();
      test_illegal();
      test_reset_midway();
      test_back_to_back();
`ifdef MC_MEM_WAIT_EN
      test_mem_wait();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
